pipe_dest_tracker: RTL
======================

// Module: pipe_dest_tracker
// PURPOSE
//  Producer side of the decode-stage hazard check. Carries each issued instruction's destination
//  register, write-enable and valid flag through the EX/MEM/WB slots, and drives the per-stage
//  compare inputs the hazard comparator reads. Consumes the comparator's active-low stall request
//  and the EX branch-flush request: holds PC and IF/ID, injects NOP bubbles into EX, counts events.
// PARAMETERS
//  REG_W      3        width of a register specifier
//  FLUSH_CYC  1        bubble cycles injected per flush (>=1)
//  STALL_MAX  3        max consecutive stall cycles before watchdog error
//  CNT_W      16       width of saturating event counters
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  id_valid     in   1      decode slot holds a real instruction (not 16'h0800 NOP)
//  id_dest      in   REG_W  destination register of decode instruction
//  id_regwrite  in   1      decode instruction writes the register file
//  stall_n      in   1      from hazard comparator; low = stall requested
//  flush        in   1      branch/jump resolved taken in EX; squash IF/ID
//  ex_dest      out  REG_W  destination in EX slot
//  mem_dest     out  REG_W  destination in MEM slot
//  wb_dest      out  REG_W  destination in WB slot
//  ex_valid_n   out  1      high = real instr in EX; low = NOP/bubble
//  mem_valid_n  out  1      as above, MEM
//  wb_valid_n   out  1      as above, WB
//  mem_wr       out  1      MEM instr writes register file
//  wb_wr        out  1      WB instr writes register file
//  pc_hold      out  1      freeze PC this cycle (combinational)
//  ifid_hold    out  1      freeze IF/ID register this cycle (combinational)
//  ifid_flush   out  1      load NOP 16'h0800 into IF/ID this cycle (combinational)
//  inject_nop   out  1      EX receives a bubble at next edge (combinational)
//  stall_cnt    out  CNT_W  saturating count of stall cycles
//  bubble_cnt   out  CNT_W  saturating count of injected bubbles (stall+flush)
//  err_watchdog out  1      sticky: stall exceeded STALL_MAX consecutive cycles
// BEHAVIOUR
//  Reset: all *_dest=0, *_valid_n=0, mem_wr=wb_wr=0, ex_wr(internal)=0, FSM=RUN, counters=0,
//   consecutive-stall counter=0, err_watchdog=0. rst wins over every other input, incl. mid-stall/flush.
//  Slot pipeline, every non-reset edge: WB<=MEM, MEM<=EX, EX<=(inject_nop ? bubble : decode).
//   Bubble = {dest=0, valid_n=0, wr=0}. Decode = {id_dest, id_valid, id_regwrite & id_valid}.
//   Latency ID->EX 1 cycle, ->MEM 2, ->WB 3. MEM/WB always advance (no back-pressure).
//  stall_req = ~stall_n & id_valid. Flush has priority over stall in the same cycle.
//  FSM states RUN, STALL, FLUSH:
//   RUN:   flush -> FLUSH (ifid_flush=1, inject_nop=1, load flush counter FLUSH_CYC-1);
//          else stall_req -> STALL (pc_hold=ifid_hold=inject_nop=1); else stay, all ctl=0.
//   STALL: flush -> FLUSH as above (stall dropped, instr squashed);
//          stall_req -> stay, hold+inject; ~stall_req -> RUN, decode instr issues this cycle.
//   FLUSH: inject_nop=1, ifid_flush=1 while flush counter>0, decrement; at 0 -> RUN.
//          FLUSH_CYC=1: FLUSH lasts zero extra cycles (returns to RUN next edge, no further bubble).
//          flush reasserted while in FLUSH reloads counter.
//  Control outputs are combinational from state+inputs, same cycle as request.
//  stall_cnt += 1 each cycle pc_hold=1; bubble_cnt += 1 each cycle inject_nop=1; both hold at
//   2^CNT_W-1 (no wrap).
//  Watchdog: consecutive-stall counter increments each stall cycle, clears on any non-stall cycle;
//   when it reaches STALL_MAX+1, err_watchdog sets and stays set until rst. Stalling continues.
//  id_valid=0 never stalls and issues a bubble (valid_n=0) without counting as injected.
// TESTING
//  1 rst held 2 cycles, then released -> all slots valid_n=0, dest=0, counters 0, err 0.
//  2 id_valid=1,id_dest=3,id_regwrite=1,stall_n=1 one cycle -> ex_dest=3 @+1, mem_dest=3,mem_wr=1 @+2,
//    wb_dest=3,wb_wr=1 @+3; slots behind carry valid_n=0.
//  3 stall_n=0 two cycles, id_valid=1 -> pc_hold=ifid_hold=1 both cycles, two bubbles in EX,
//    stall_cnt=2, bubble_cnt=2, instr issues cycle 3.
//  4 stall_n=0 and flush=1 same cycle, FLUSH_CYC=2 -> pc_hold=0, ifid_flush=1 two cycles,
//    bubble_cnt=2, stall_cnt=0.
//  5 stall_n=0 for 5 cycles, STALL_MAX=3 -> err_watchdog rises after 4th stall cycle, stays 1; rst clears.
//  6 CNT_W=4, 20 stall cycles -> stall_cnt=15 held; rst asserted mid-stall -> FSM RUN, holds drop next cycle.

Source files
------------

// File: rtl/pipe_dest_tracker.sv
// pipe_dest_tracker
//   Producer side of the decode-stage hazard check. Carries each issued
//   instruction's destination register, write-enable and valid flag through
//   the EX/MEM/WB slots so the hazard comparator can read them. Consumes the
//   comparator's active-low stall request and the EX branch-flush request.
//   On a stall it holds PC and IF/ID. On a flush it squashes IF/ID. In both
//   cases it puts a NOP bubble into EX. It also keeps saturating event
//   counters and a sticky stall watchdog.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   id_valid/id_dest/id_regwrite
//                            decode-slot instruction
//   stall_n                  hazard comparator stall request (low = stall)
//   flush                    taken branch/jump resolved in EX
//   ex/mem/wb_dest, *_valid_n, mem_wr, wb_wr
//                            per-stage compare inputs (valid_n high = real instr)
//   pc_hold, ifid_hold, ifid_flush, inject_nop
//                            combinational pipeline controls
//   stall_cnt, bubble_cnt    saturating event counters
//   err_watchdog             sticky: stall ran longer than STALL_MAX cycles
module pipe_dest_tracker #(
   parameter int REG_W     = 3,
   parameter int FLUSH_CYC = 1,
   parameter int STALL_MAX = 3,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_regwrite,
   input  logic             stall_n,
   input  logic             flush,
   output logic [REG_W-1:0] ex_dest,
   output logic [REG_W-1:0] mem_dest,
   output logic [REG_W-1:0] wb_dest,
   output logic             ex_valid_n,
   output logic             mem_valid_n,
   output logic             wb_valid_n,
   output logic             mem_wr,
   output logic             wb_wr,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             inject_nop,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic             err_watchdog
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   // The flush counter holds the number of extra bubble cycles still owed
   // after the request cycle, so it only needs to reach FLUSH_CYC-1.
   localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);

   // The watchdog counter saturates at STALL_MAX+1, which is the trip point.
   localparam int WD_W = $clog2(STALL_MAX + 2);
   localparam logic [WD_W-1:0] WD_TOP  = WD_W'(STALL_MAX + 1);
   localparam logic [WD_W-1:0] WD_TRIP = WD_W'(STALL_MAX);

   state_t          state, state_nxt;
   logic [FC_W-1:0] fcnt, fcnt_nxt;
   logic [WD_W-1:0] wd_cnt;
   logic            ex_wr;
   logic            stall_req;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A slot that holds no real instruction never asks for a stall.
   assign stall_req = ~stall_n & id_valid;

   // RUN and STALL react to requests in the same way. Flush beats stall,
   // and a stalled decode instruction that meets a flush is squashed.
   always_comb begin
      state_nxt  = state;
      fcnt_nxt   = fcnt;
      pc_hold    = 1'b0;
      ifid_hold  = 1'b0;
      ifid_flush = 1'b0;
      inject_nop = 1'b0;
      case (state)
         RUN, STALL: begin
            if (flush) begin
               ifid_flush = 1'b1;
               inject_nop = 1'b1;
               fcnt_nxt   = FC_LOAD;
               state_nxt  = (FLUSH_CYC > 1) ? FLUSH : RUN;
            end else if (stall_req) begin
               pc_hold    = 1'b1;
               ifid_hold  = 1'b1;
               inject_nop = 1'b1;
               state_nxt  = STALL;
            end else begin
               state_nxt  = RUN;
            end
         end
         FLUSH: begin
            ifid_flush = 1'b1;
            inject_nop = 1'b1;
            if (flush) begin
               // A new taken branch restarts the bubble train.
               fcnt_nxt  = FC_LOAD;
               state_nxt = (FLUSH_CYC > 1) ? FLUSH : RUN;
            end else begin
               fcnt_nxt = (fcnt == '0) ? '0 : fcnt - FC_W'(1);
               if (fcnt <= FC_W'(1)) state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         fcnt         <= '0;
         ex_dest      <= '0;
         mem_dest     <= '0;
         wb_dest      <= '0;
         ex_valid_n   <= 1'b0;
         mem_valid_n  <= 1'b0;
         wb_valid_n   <= 1'b0;
         ex_wr        <= 1'b0;
         mem_wr       <= 1'b0;
         wb_wr        <= 1'b0;
         stall_cnt    <= '0;
         bubble_cnt   <= '0;
         wd_cnt       <= '0;
         err_watchdog <= 1'b0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;

         // ID -> EX boundary
         ex_dest    <= inject_nop ? '0   : id_dest;
         ex_valid_n <= inject_nop ? 1'b0 : id_valid;
         ex_wr      <= ~inject_nop & id_regwrite & id_valid;

         // EX -> MEM boundary
         mem_dest    <= ex_dest;
         mem_valid_n <= ex_valid_n;
         mem_wr      <= ex_wr;

         // MEM -> WB boundary
         wb_dest    <= mem_dest;
         wb_valid_n <= mem_valid_n;
         wb_wr      <= mem_wr;

         if (pc_hold)    stall_cnt  <= sat_inc(stall_cnt);
         if (inject_nop) bubble_cnt <= sat_inc(bubble_cnt);

         // The watchdog trips on the edge where the run of consecutive
         // stall cycles reaches STALL_MAX+1. Stalling itself is not stopped.
         if (pc_hold) begin
            if (wd_cnt != WD_TOP)  wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_TRIP) err_watchdog <= 1'b1;
         end else begin
            wd_cnt <= '0;
         end
      end
   end

endmodule
